// File: rtl/axis_gcd_sched.sv
// Round-robin AXI4-Stream scheduler over NUM_CORES binary-GCD cores.
// Each slot holds its result until the in-order collector drains it.
module gcd_core (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        done,
  output logic [31:0] r
);
  logic        busy;
  logic [31:0] x, y;
  logic [4:0]  k;

  // Stein's algorithm: bounded iteration count, no divider.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      busy <= 1'b0; done <= 1'b0; r <= '0; x <= '0; y <= '0; k <= '0;
    end else begin
      done <= 1'b0;
      if (start) begin
        x <= a; y <= b; k <= '0; busy <= 1'b1;
      end else if (busy) begin
        if (x == '0) begin
          r <= y << k; done <= 1'b1; busy <= 1'b0;
        end else if (y == '0) begin
          r <= x << k; done <= 1'b1; busy <= 1'b0;
        end else if (!x[0] && !y[0]) begin
          x <= x >> 1; y <= y >> 1; k <= k + 5'd1;
        end else if (!x[0]) begin
          x <= x >> 1;
        end else if (!y[0]) begin
          y <= y >> 1;
        end else if (x >= y) begin
          x <= x - y;
        end else begin
          y <= y - x;
        end
      end
    end
  end
endmodule

module axis_gcd_sched #(
  parameter int NUM_CORES = 2
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic [63:0] s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  input  logic        s_axis_tlast,
  output logic [31:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast,
  output logic [3:0]  inflight
);
  localparam int PTR_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  typedef enum logic [1:0] {IDLE, START, RUN, HOLD} slot_t;

  slot_t                        st [NUM_CORES];
  slot_t                        st_nxt [NUM_CORES];
  logic [PTR_W-1:0]             disp_ptr, coll_ptr;
  logic [NUM_CORES-1:0][31:0]   a_reg, b_reg, res_reg, core_r;
  logic [NUM_CORES-1:0]         last_reg, core_done, core_start;
  logic                         in_hs, out_hs;

  assign in_hs  = s_axis_tvalid & s_axis_tready;
  assign out_hs = m_axis_tvalid & m_axis_tready;

  // Handshake sides decode registered slot state only; tready is held low in reset.
  always_comb begin
    s_axis_tready = 1'b0;
    m_axis_tvalid = 1'b0;
    m_axis_tdata  = '0;
    m_axis_tlast  = 1'b0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (disp_ptr == PTR_W'(i)) s_axis_tready = aresetn && (st[i] == IDLE);
      if (coll_ptr == PTR_W'(i)) begin
        m_axis_tvalid = (st[i] == HOLD);
        m_axis_tdata  = res_reg[i];
        m_axis_tlast  = last_reg[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_CORES; i++) begin
      st_nxt[i]     = st[i];
      core_start[i] = (st[i] == START);
      case (st[i])
        IDLE:    if (in_hs && disp_ptr == PTR_W'(i)) st_nxt[i] = START;
        START:   st_nxt[i] = RUN;
        RUN:     if (core_done[i]) st_nxt[i] = HOLD;
        HOLD:    if (out_hs && coll_ptr == PTR_W'(i)) st_nxt[i] = IDLE;
        default: st_nxt[i] = IDLE;
      endcase
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      for (int i = 0; i < NUM_CORES; i++) st[i] <= IDLE;
      disp_ptr <= '0;
      coll_ptr <= '0;
      a_reg    <= '0;
      b_reg    <= '0;
      res_reg  <= '0;
      last_reg <= '0;
      inflight <= '0;
    end else begin
      for (int i = 0; i < NUM_CORES; i++) begin
        st[i] <= st_nxt[i];
        if (st[i] == IDLE && in_hs && disp_ptr == PTR_W'(i)) begin
          a_reg[i]    <= s_axis_tdata[31:0];
          b_reg[i]    <= s_axis_tdata[63:32];
          last_reg[i] <= s_axis_tlast;
        end
        if (st[i] == RUN && core_done[i]) res_reg[i] <= core_r[i];
      end
      if (in_hs)
        disp_ptr <= (disp_ptr == PTR_W'(NUM_CORES-1)) ? '0 : disp_ptr + PTR_W'(1);
      if (out_hs)
        coll_ptr <= (coll_ptr == PTR_W'(NUM_CORES-1)) ? '0 : coll_ptr + PTR_W'(1);
      case ({in_hs, out_hs})
        2'b10:   inflight <= inflight + 4'd1;
        2'b01:   inflight <= inflight - 4'd1;
        default: inflight <= inflight;
      endcase
    end
  end

  for (genvar g = 0; g < NUM_CORES; g++) begin : g_core
    gcd_core u_core (
      .aclk    (aclk),
      .aresetn (aresetn),
      .start   (core_start[g]),
      .a       (a_reg[g]),
      .b       (b_reg[g]),
      .done    (core_done[g]),
      .r       (core_r[g])
    );
  end
endmodule

// File: tb/tb_axis_gcd_sched.sv
// Randomized bench for axis_gcd_sched against a Euclid-by-modulo reference
// and an in-order scoreboard of {tlast, gcd} per accepted beat.
module tb_axis_gcd_sched;
  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic [63:0] s_axis_tdata = '0;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tlast = 1'b0;
  logic        s_axis_tready;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tlast;
  logic        m_axis_tready = 1'b0;
  logic [3:0]  inflight;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [32:0] acc_q[$];
  logic [32:0] out_q[$];
  int          acc_cyc[$];
  int          out_cyc[$];

  always #5 aclk = ~aclk;

  axis_gcd_sched #(.NUM_CORES(2)) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .inflight      (inflight)
  );

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] gcd_ref(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] t;
    while (b != 0) begin t = a % b; a = b; b = t; end
    return a;
  endfunction

  function automatic logic [63:0] pair(input logic [31:0] a, input logic [31:0] b);
    return {b, a};
  endfunction

  // Called at a negedge with inputs already set; logs handshakes of the coming edge.
  task automatic tick();
    if (s_axis_tvalid && s_axis_tready) begin
      acc_q.push_back({s_axis_tlast, gcd_ref(s_axis_tdata[31:0], s_axis_tdata[63:32])});
      acc_cyc.push_back(cyc);
    end
    if (m_axis_tvalid && m_axis_tready) begin
      out_q.push_back({m_axis_tlast, m_axis_tdata});
      out_cyc.push_back(cyc);
    end
    cyc++;
    @(negedge aclk);
  endtask

  task automatic clear_q();
    acc_q.delete(); out_q.delete(); acc_cyc.delete(); out_cyc.delete();
  endtask

  task automatic apply_reset();
    aresetn = 1'b0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; m_axis_tready = 1'b0;
    tick(); tick();
    aresetn = 1'b1;
    tick();
    clear_q();
  endtask

  task automatic send(input logic [63:0] d, input logic last, output bit ok);
    bit hs;
    ok = 0;
    s_axis_tdata = d; s_axis_tlast = last; s_axis_tvalid = 1'b1;
    for (int i = 0; i < 500; i++) begin
      hs = s_axis_tvalid && s_axis_tready;
      tick();
      if (hs) begin ok = 1; break; end
    end
    s_axis_tvalid = 1'b0;
  endtask

  task automatic wait_out(input int n, input int budget);
    for (int i = 0; i < budget && out_q.size() < n; i++) tick();
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    @(negedge aclk);
    tick(); tick(); tick();
    checks++; if (s_axis_tready !== 1'b0) begin failures++; $display("FAIL rst_s_tready got=%b exp=0", s_axis_tready); end
    checks++; if (m_axis_tvalid !== 1'b0) begin failures++; $display("FAIL rst_m_tvalid got=%b exp=0", m_axis_tvalid); end
    checks++; if (m_axis_tdata !== 32'd0) begin failures++; $display("FAIL rst_m_tdata got=%0d exp=0", m_axis_tdata); end
    checks++; if (m_axis_tlast !== 1'b0) begin failures++; $display("FAIL rst_m_tlast got=%b exp=0", m_axis_tlast); end
    checks++; if (inflight !== 4'd0) begin failures++; $display("FAIL rst_inflight got=%0d exp=0", inflight); end
    aresetn = 1'b1;
    tick();
    checks++; if (s_axis_tready !== 1'b1) begin failures++; $display("FAIL post_rst_s_tready got=%b exp=1", s_axis_tready); end
    clear_q();
  endtask

  task automatic test_single();
    bit ok;
    apply_reset();
    m_axis_tready = 1'b1;
    send(64'h00000012_00000030, 1'b1, ok);
    checks++; if (!ok) begin failures++; $display("FAIL single_accept got=timeout exp=accepted"); end
    checks++; if (dut.core_start[0] !== 1'b1) begin failures++; $display("FAIL single_start got=%b exp=1", dut.core_start[0]); end
    checks++; if (inflight !== 4'd1) begin failures++; $display("FAIL single_inflight1 got=%0d exp=1", inflight); end
    tick();
    checks++; if (dut.core_start[0] !== 1'b0) begin failures++; $display("FAIL single_start_pulse got=%b exp=0", dut.core_start[0]); end
    wait_out(1, 300);
    checks++;
    if (out_q.size() != 1 || out_q[0] !== {1'b1, 32'd6}) begin
      failures++; $display("FAIL single_result got_n=%0d got=%h exp=%h", out_q.size(), out_q.size() ? out_q[0] : 33'h0, {1'b1, 32'd6});
    end
    checks++; if (inflight !== 4'd0) begin failures++; $display("FAIL single_inflight0 got=%0d exp=0", inflight); end
  endtask

  task automatic test_stream();
    bit ok;
    logic [63:0] d [4];
    logic [32:0] exp_v [4];
    d = '{pair(48, 18), pair(17, 5), pair(100, 75), pair(21, 14)};
    exp_v = '{{1'b0, 32'd6}, {1'b0, 32'd1}, {1'b0, 32'd25}, {1'b1, 32'd7}};
    apply_reset();
    m_axis_tready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send(d[i], i == 3, ok);
      checks++; if (!ok) begin failures++; $display("FAIL stream_accept%0d got=timeout exp=accepted", i); end
    end
    wait_out(4, 1000);
    checks++; if (out_q.size() != 4) begin failures++; $display("FAIL stream_count got=%0d exp=4", out_q.size()); end
    for (int i = 0; i < 4 && i < out_q.size(); i++) begin
      checks++;
      if (out_q[i] !== exp_v[i]) begin failures++; $display("FAIL stream_beat%0d got=%h exp=%h", i, out_q[i], exp_v[i]); end
    end
  endtask

  task automatic test_ordering();
    bit ok;
    apply_reset();
    m_axis_tready = 1'b1;
    send(pair(1836311903, 1134903170), 1'b0, ok);
    send(pair(8, 4), 1'b1, ok);
    wait_out(2, 1000);
    checks++;
    if (out_q.size() != 2 || out_q[0] !== {1'b0, 32'd1} || out_q[1] !== {1'b1, 32'd4}) begin
      failures++;
      $display("FAIL ordering got_n=%0d first=%h second=%h exp=%h,%h", out_q.size(),
               out_q.size() > 0 ? out_q[0] : 33'h0, out_q.size() > 1 ? out_q[1] : 33'h0,
               {1'b0, 32'd1}, {1'b1, 32'd4});
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] d [3];
    logic [31:0] hold;
    int k;
    bit hs;
    d = '{pair(48, 18), pair(17, 5), pair(100, 75)};
    apply_reset();
    m_axis_tready = 1'b0;
    k = 0;
    s_axis_tdata = d[0]; s_axis_tlast = 1'b0; s_axis_tvalid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      hs = s_axis_tvalid && s_axis_tready;
      tick();
      if (hs) begin k++; if (k < 3) s_axis_tdata = d[k]; end
    end
    checks++; if (k != 2) begin failures++; $display("FAIL bp_accepted got=%0d exp=2", k); end
    checks++; if (s_axis_tready !== 1'b0) begin failures++; $display("FAIL bp_s_tready got=%b exp=0", s_axis_tready); end
    checks++; if (inflight !== 4'd2) begin failures++; $display("FAIL bp_inflight got=%0d exp=2", inflight); end
    checks++; if (m_axis_tvalid !== 1'b1) begin failures++; $display("FAIL bp_m_tvalid got=%b exp=1", m_axis_tvalid); end
    hold = m_axis_tdata;
    tick(); tick(); tick(); tick();
    checks++;
    if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 32'd6 || hold !== 32'd6) begin
      failures++; $display("FAIL bp_stable got=%0d/%0d vld=%b exp=6", hold, m_axis_tdata, m_axis_tvalid);
    end
    m_axis_tready = 1'b1;
    for (int i = 0; i < 300 && k < 3; i++) begin
      hs = s_axis_tvalid && s_axis_tready;
      tick();
      if (hs) k++;
    end
    s_axis_tvalid = 1'b0;
    wait_out(3, 500);
    checks++;
    if (acc_cyc.size() != 3 || out_cyc.size() == 0 || acc_cyc[2] <= out_cyc[0]) begin
      failures++;
      $display("FAIL bp_reuse_timing got_acc=%0d got_out=%0d exp=acc_after_out",
               acc_cyc.size() > 2 ? acc_cyc[2] : -1, out_cyc.size() > 0 ? out_cyc[0] : -1);
    end
    checks++;
    if (out_q.size() != 3 || out_q[0] !== {1'b0, 32'd6} || out_q[1] !== {1'b0, 32'd1} || out_q[2] !== {1'b0, 32'd25}) begin
      failures++; $display("FAIL bp_results got_n=%0d exp=3 beats 6,1,25", out_q.size());
    end
  endtask

  function automatic logic [31:0] rand_op(input int kind, input logic [31:0] g);
    logic [31:0] v;
    case (kind)
      0:       v = $urandom;
      1:       v = g * $urandom_range(1, 60000);
      default: v = $urandom_range(1, 100);
    endcase
    return (v == 0) ? 32'd1 : v;
  endfunction

  task automatic test_random();
    int n_sent;
    int kind;
    logic [31:0] g;
    bit hs;
    apply_reset();
    n_sent = 0;
    for (int c = 0; c < 40000 && (n_sent < 200 || out_q.size() < 200); c++) begin
      m_axis_tready = ($urandom_range(0, 1) == 1);
      hs = s_axis_tvalid && s_axis_tready;
      tick();
      if (hs) begin s_axis_tvalid = 1'b0; n_sent++; end
      if (!s_axis_tvalid && n_sent < 200 && $urandom_range(0, 3) != 0) begin
        kind = $urandom_range(0, 2);
        g = $urandom_range(1, 5000);
        s_axis_tdata  = {rand_op(kind, g), rand_op(kind, g)};
        s_axis_tlast  = ($urandom_range(0, 4) == 0);
        s_axis_tvalid = 1'b1;
      end
    end
    s_axis_tvalid = 1'b0;
    checks++; if (acc_q.size() != 200) begin failures++; $display("FAIL rand_accepted got=%0d exp=200", acc_q.size()); end
    checks++; if (out_q.size() != 200) begin failures++; $display("FAIL rand_outputs got=%0d exp=200", out_q.size()); end
    for (int i = 0; i < out_q.size() && i < acc_q.size(); i++) begin
      checks++;
      if (out_q[i] !== acc_q[i]) begin failures++; $display("FAIL rand_beat%0d got=%h exp=%h", i, out_q[i], acc_q[i]); end
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    apply_reset();
    m_axis_tready = 1'b1;
    send(pair(1836311903, 1134903170), 1'b0, ok);
    send(pair(1134903170, 701408733), 1'b1, ok);
    tick(); tick(); tick();
    checks++; if (inflight !== 4'd2) begin failures++; $display("FAIL mid_inflight_pre got=%0d exp=2", inflight); end
    aresetn = 1'b0;
    tick();
    checks++;
    if (m_axis_tvalid !== 1'b0 || s_axis_tready !== 1'b0 || m_axis_tdata !== 32'd0 || m_axis_tlast !== 1'b0 || inflight !== 4'd0) begin
      failures++;
      $display("FAIL mid_reset_outputs got vld=%b rdy=%b data=%0d last=%b infl=%0d exp=all0",
               m_axis_tvalid, s_axis_tready, m_axis_tdata, m_axis_tlast, inflight);
    end
    aresetn = 1'b1;
    clear_q();
    for (int i = 0; i < 200; i++) tick();
    checks++; if (out_q.size() != 0) begin failures++; $display("FAIL mid_stale got=%0d beats exp=0", out_q.size()); end
    send(pair(48, 18), 1'b1, ok);
    wait_out(1, 300);
    checks++;
    if (out_q.size() != 1 || out_q[0] !== {1'b1, 32'd6}) begin
      failures++; $display("FAIL mid_after got_n=%0d got=%h exp=%h", out_q.size(), out_q.size() ? out_q[0] : 33'h0, {1'b1, 32'd6});
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_stream();
    test_ordering();
    test_backpressure();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
